// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter.
// Optional feature macro: RAM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package ram_arb_pkg;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   localparam int unsigned MAX_MASTERS = 8;

   // Search upward from ptr with wrap over n requesters; return one-hot grant of first hit.
   function automatic logic [MAX_MASTERS-1:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                                       input logic [2:0]             ptr,
                                                       input int unsigned            n);
      logic [MAX_MASTERS-1:0] gnt;
      logic                   found;
      int unsigned            idx;
      logic [2:0]             idx3;
      gnt   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
         if (i < n) begin
            idx  = (32'(ptr) + i) % n;
            idx3 = 3'(idx);
            if (!found && req[idx3]) begin
               gnt[idx3] = 1'b1;
               found     = 1'b1;
            end
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-port arbiter: one-hot grant plus index, pointer advanced only on accept.
// Optional feature macro: RAM_ARB_FIXED_PRIO_EN (lowest index always wins, no pointer).
module rr_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req_i,
   input  logic             accept_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] grantIdx_o,
   output logic             any_o
);

   logic [IDX_W-1:0] ptr;

`ifdef RAM_ARB_FIXED_PRIO_EN
   localparam arb_mode_e MODE = ARB_FIXED;

   // No pointer state in fixed-priority mode.
   logic unused_ok;
   assign unused_ok = &{1'b0, clk, rst_n, accept_i};
   assign ptr       = '0;
`else
   localparam arb_mode_e        MODE = ARB_RR;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   logic [IDX_W-1:0] ptr_q, ptr_d;

   // Next pointer: one past the accepted winner, wrapping; hold when nothing accepted.
   always_comb begin
      ptr_d = ptr_q;
      if (accept_i) begin
         ptr_d = (grantIdx_o == LAST) ? '0 : grantIdx_o + 1'b1;
      end
   end

   // Pointer register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
`endif

   logic [IDX_W-1:0] ptrPick;
   assign ptrPick = (MODE == ARB_FIXED) ? '0 : ptr;

   assign grant_o = N'(rr_pick(8'(req_i), 3'(ptrPick), N));
   assign any_o   = |req_i;

   // Encode the one-hot grant into an index.
   always_comb begin
      grantIdx_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_o[i]) grantIdx_o = IDX_W'(i);
      end
   end

endmodule

// File: rtl/dual_port_ram_arbiter.sv
// Arbitrates NUM_MASTERS readers/writers onto one simple-dual-port RAM.
// Same-cycle same-address read/write collisions alternate between sides so the
// RAM's undefined mixed-port read-during-write result is never returned.
// Optional feature macro: RAM_ARB_FIXED_PRIO_EN (fixed priority on both ports).
module dual_port_ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter  int unsigned NUM_MASTERS = 2,
   parameter  int unsigned WIDTH       = 32,
   parameter  int unsigned DEPTH       = 1024,
   localparam int unsigned ADDR_WIDTH  = $clog2(DEPTH),
   localparam int unsigned BE_WIDTH    = WIDTH / 8,
   localparam int unsigned IDX_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_MASTERS-1:0]                 rdReq,
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] rdAddr,
   output logic [NUM_MASTERS-1:0]                 rdReady,
   output logic [NUM_MASTERS-1:0]                 rdValid,
   output logic [WIDTH-1:0]                       rdData,
   input  logic [NUM_MASTERS-1:0]                 wrReq,
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] wrAddr,
   input  logic [NUM_MASTERS-1:0][WIDTH-1:0]      wrData,
   input  logic [NUM_MASTERS-1:0][BE_WIDTH-1:0]   wrByteEn,
   output logic [NUM_MASTERS-1:0]                 wrReady,
   output logic [ADDR_WIDTH-1:0]                  ramReadAddress,
   input  logic [WIDTH-1:0]                       ramReadData,
   output logic [ADDR_WIDTH-1:0]                  ramWriteAddress,
   output logic [WIDTH-1:0]                       ramWriteData,
   output logic                                   ramWriteEnable,
   output logic [BE_WIDTH-1:0]                    ramWriteByteEnable
);

   logic [NUM_MASTERS-1:0] rdGnt, wrGnt;
   logic [IDX_WIDTH-1:0]   rdIdx, wrIdx;
   logic                   rdAny, wrAny;
   logic                   rdAcc, wrAcc;
   logic                   collide;

   logic                   rawStall_q, rawStall_d;
   logic                   rdPend_q, rdPend_d;
   logic [IDX_WIDTH-1:0]   rdIdx_q, rdIdx_d;
   logic [ADDR_WIDTH-1:0]  rdAddrHold_q, rdAddrHold_d;

   rr_arbiter #(.N(NUM_MASTERS), .IDX_W(IDX_WIDTH)) u_rd_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (rdReq),
      .accept_i   (rdAcc),
      .grant_o    (rdGnt),
      .grantIdx_o (rdIdx),
      .any_o      (rdAny)
   );

   rr_arbiter #(.N(NUM_MASTERS), .IDX_W(IDX_WIDTH)) u_wr_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (wrReq),
      .accept_i   (wrAcc),
      .grant_o    (wrGnt),
      .grantIdx_o (wrIdx),
      .any_o      (wrAny)
   );

   // Collision resolution: write wins when not already stalled, read wins next time.
   always_comb begin
      collide    = rdAny && wrAny && (rdAddr[rdIdx] == wrAddr[wrIdx]);
      wrAcc      = rst_n && wrAny && !(collide && rawStall_q);
      rdAcc      = rst_n && rdAny && !(collide && !rawStall_q);
      rawStall_d = collide ? !rawStall_q : 1'b0;
   end

   // Handshake and RAM-side drive; enables are forced low while in reset.
   always_comb begin
      rdReady            = rdAcc ? rdGnt : '0;
      wrReady            = wrAcc ? wrGnt : '0;
      ramWriteEnable     = wrAcc;
      ramWriteAddress    = wrAddr[wrIdx];
      ramWriteData       = wrData[wrIdx];
      ramWriteByteEnable = wrAcc ? wrByteEn[wrIdx] : '0;
      ramReadAddress     = rdAny ? rdAddr[rdIdx] : rdAddrHold_q;
   end

   // Read-return pipeline next state: remember who was accepted.
   always_comb begin
      rdPend_d     = rdAcc;
      rdIdx_d      = rdAcc ? rdIdx : rdIdx_q;
      rdAddrHold_d = ramReadAddress;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rawStall_q   <= 1'b0;
         rdPend_q     <= 1'b0;
         rdIdx_q      <= '0;
         rdAddrHold_q <= '0;
      end else begin
         rawStall_q   <= rawStall_d;
         rdPend_q     <= rdPend_d;
         rdIdx_q      <= rdIdx_d;
         rdAddrHold_q <= rdAddrHold_d;
      end
   end

   // Return data one cycle after accept, tagged to the accepted master.
   always_comb begin
      rdValid = '0;
      if (rdPend_q) rdValid[rdIdx_q] = 1'b1;
      rdData = ramReadData;
   end

endmodule
